// File: rtl/mux4_is_to_1.sv
// mux4_is_to_1: selects one of four WIDTH-bit inputs under {s1,s0}; y combinational, y_q registered copy.
// Latency: y is zero-cycle; y_q is one clk cycle behind y.
// Backpressure: none; pure datapath leaf that accepts new inputs every cycle.
module mux4_is_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;

  // s1 is the MSB of the select; the pair indexes d0..d3 directly.
  assign w_sel = {s1, s0};

  // Fully decoded 4:1 choice; the default assignment keeps the block latch-free
  // and gives synthesis a plain mux even if the select is ever unknown in sim.
  always_comb begin
    w_y = d0;
    case (w_sel)
      2'b00:   w_y = d0;
      2'b01:   w_y = d1;
      2'b10:   w_y = d2;
      2'b11:   w_y = d3;
      default: w_y = d0;
    endcase
  end

  // Registered copy of the mux result; reset clears only this path, never y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= w_y;
    end
  end

  assign y   = w_y;
  assign y_q = r_y_q;

endmodule

// File: tb/tb_mux4_is_to_1.sv
// tb_mux4_is_to_1: directed bench for the 4:1 selector at WIDTH=1 and WIDTH=8.
// Latency: checks y at zero cycles and y_q one rising edge later.
// Backpressure: none; expected values are queued as stimulus is driven and popped on compare.
module tb_mux4_is_to_1;

  logic       clk;
  logic       rst_n;

  // WIDTH=1 instance signals
  logic       a_d0, a_d1, a_d2, a_d3, a_s0, a_s1;
  logic       a_y, a_y_q;

  // WIDTH=8 instance signals
  logic [7:0] b_d0, b_d1, b_d2, b_d3;
  logic       b_s0, b_s1;
  logic [7:0] b_y, b_y_q;

  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_err;

  mux4_is_to_1 #(.WIDTH(1)) u_dut_w1 (
    .clk  (clk),
    .rst_n(rst_n),
    .d0   (a_d0),
    .d1   (a_d1),
    .d2   (a_d2),
    .d3   (a_d3),
    .s0   (a_s0),
    .s1   (a_s1),
    .y    (a_y),
    .y_q  (a_y_q)
  );

  mux4_is_to_1 #(.WIDTH(8)) u_dut_w8 (
    .clk  (clk),
    .rst_n(rst_n),
    .d0   (b_d0),
    .d1   (b_d1),
    .d2   (b_d2),
    .d3   (b_d3),
    .s0   (b_s0),
    .s1   (b_s1),
    .y    (b_y),
    .y_q  (b_y_q)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops the oldest expected value and compares it against the observed output.
  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s scoreboard empty, got=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s got=%h exp=%h", tag, obs, e);
      end
    end
  endtask

  initial begin
    logic [7:0] t1_exp [4];
    logic [7:0] t3_exp [4];
    logic [5:0] pv;
    logic [7:0] d2_seq [3];
    logic [1:0] sel;

    n_checks = 0;
    n_err    = 0;
    t1_exp   = '{8'h00, 8'h01, 8'h00, 8'h01};
    t3_exp   = '{8'h11, 8'h22, 8'h44, 8'h88};
    d2_seq   = '{8'h00, 8'hFF, 8'h00};

    // ---- Reset state ----
    rst_n = 1'b0;
    {a_d0, a_d1, a_d2, a_d3, a_s0, a_s1} = '0;
    b_d0 = 8'h00; b_d1 = 8'h00; b_d2 = 8'h00; b_d3 = 8'h00;
    b_s0 = 1'b0;  b_s1 = 1'b0;
    #3;
    exp_q.push_back(8'h00); chk("rst_yq_w1", {7'b0, a_y_q});
    exp_q.push_back(8'h00); chk("rst_yq_w8", b_y_q);

    // y must be live while reset is held
    b_d0 = 8'h11; b_d1 = 8'h22; b_d2 = 8'h44; b_d3 = 8'h88;
    b_s1 = 1'b1;  b_s0 = 1'b1;
    exp_q.push_back(8'h88);
    #1 chk("rst_y_live", b_y);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(8'h00); chk("rst_yq_hold", b_y_q);

    @(negedge clk);
    rst_n = 1'b1;

    // ---- 1: static route, WIDTH=1 ----
    a_d0 = 1'b0; a_d1 = 1'b1; a_d2 = 1'b0; a_d3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      {a_s1, a_s0} = sel;
      exp_q.push_back(t1_exp[i]);
      #100;
      chk("static_w1", {7'b0, a_y});
    end

    // ---- 2: exhaustive WIDTH=1 ----
    for (int p = 0; p < 64; p++) begin
      pv = p[5:0];
      {a_d3, a_d2, a_d1, a_d0, a_s1, a_s0} = pv;
      exp_q.push_back({7'b0, pv[2 + pv[1:0]]});
      #1;
      chk("exhaust_w1", {7'b0, a_y});
    end

    // ---- 3: WIDTH=8 select sweep ----
    b_d0 = 8'h11; b_d1 = 8'h22; b_d2 = 8'h44; b_d3 = 8'h88;
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      {b_s1, b_s0} = sel;
      exp_q.push_back(t3_exp[i]);
      #1;
      chk("sweep_w8", b_y);
    end

    // ---- 4: registered path ----
    @(negedge clk);
    {b_s1, b_s0} = 2'b00;
    exp_q.push_back(8'h11);
    @(posedge clk);
    #1 chk("reg_load_d0", b_y_q);
    @(negedge clk);
    #2 {b_s1, b_s0} = 2'b11;
    exp_q.push_back(8'h88);
    #1 chk("reg_y_now", b_y);
    exp_q.push_back(8'h11);
    chk("reg_yq_old", b_y_q);
    exp_q.push_back(8'h88);
    @(posedge clk);
    #1 chk("reg_yq_new", b_y_q);

    // ---- 5: async reset mid-cycle ----
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.push_back(8'h00);
    #1 chk("arst_yq_clr", b_y_q);
    exp_q.push_back(8'h88);
    chk("arst_y_kept", b_y);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h00); chk("arst_yq_hold", b_y_q);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back(8'h00); chk("arst_rel_noedge", b_y_q);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h88); chk("arst_rel_load", b_y_q);

    // ---- 6: fixed select, only d2 matters ----
    @(negedge clk);
    {b_s1, b_s0} = 2'b10;
    for (int i = 0; i < 3; i++) begin
      b_d0 = 8'($urandom);
      b_d1 = 8'($urandom);
      b_d3 = 8'($urandom);
      b_d2 = d2_seq[i];
      exp_q.push_back(d2_seq[i]);
      #1;
      chk("d2_track", b_y);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
